csr_debug_bridge: RTL and testbench

- Initiator-side bridge that lets a host or debug port access the control/status register file.
- Accepts read/write/set/clear requests on a valid/ready interface and takes ownership of the CSR port from the core.
- Performs read-modify-write locally, because the register file only writes whole words, and returns the old value on a response channel.
- Sits between the core's CSR issue signals and the register file's command/address/data port.

---
 rtl/csr_debug_bridge.sv | 152 +++++++++++++++
 tb/tb_csr_debug_bridge.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_debug_bridge.sv
// Host/debug bridge into the CSR file. It waits for the core to release the
// port, then does a local read-modify-write and returns the old value.
package Bundle;
  typedef enum logic [2:0] {
    CSR_N = 3'd0,
    CSR_R = 3'd2,
    CSR_I = 3'd4,
    CSR_W = 3'd5,
    CSR_S = 3'd6,
    CSR_C = 3'd7
  } ControlRegisterCommand;
endpackage

// state  | meaning
// IDLE   | ready for a host request
// STALL  | core stalled, waiting for it to drive CSR_N (bounded by timeout)
// READ   | bridge owns the port, captures old value
// WRITE  | bridge owns the port, writes the resolved new value
// RESP   | response held until the host accepts it
module csr_debug_bridge #(
  parameter int width   = 32,
  parameter int timeout = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_op,
  input  logic [11:0]                   req_addr,
  input  logic [width-1:0]              req_data,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [width-1:0]              resp_rdata,
  output logic                          resp_err,
  input  Bundle::ControlRegisterCommand core_csr_cmd,
  input  logic [11:0]                   core_csr,
  input  logic [width-1:0]              core_csr_wdata,
  output logic                          core_stall,
  output Bundle::ControlRegisterCommand csr_cmd,
  output logic [11:0]                   csr,
  output logic [width-1:0]              csr_wdata,
  input  logic [width-1:0]              csr_rdata
);
  localparam int CW = $clog2(timeout + 1);
  localparam logic [CW-1:0] TO_LOAD = CW'(timeout);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_SET   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_STALL, S_READ, S_WRITE, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [11:0]      addr_q, addr_d;
  logic [width-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [width-1:0] new_val;
  logic             bridge_own;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          data_d  = req_data;
          cnt_d   = TO_LOAD;
          state_d = S_STALL;
        end
      end
      S_STALL: begin
        if (core_csr_cmd == Bundle::CSR_N) begin
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_d == '0) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      S_READ: begin
        rdata_d = csr_rdata;
        state_d = (op_q == OP_READ) ? S_RESP : S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // rdata_q holds the old value captured in READ; it is also the response.
  always_comb begin
    case (op_q)
      OP_WRITE: new_val = data_q;
      OP_SET:   new_val = rdata_q | data_q;
      OP_CLEAR: new_val = rdata_q & ~data_q;
      default:  new_val = rdata_q;
    endcase
  end

  // Reset releases the port immediately, even mid-access.
  assign bridge_own = reset_n && ((state_q == S_READ) || (state_q == S_WRITE));

  assign csr_cmd    = bridge_own ? ((state_q == S_WRITE) ? Bundle::CSR_W : Bundle::CSR_N)
                                 : core_csr_cmd;
  assign csr        = bridge_own ? addr_q  : core_csr;
  assign csr_wdata  = bridge_own ? new_val : core_csr_wdata;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign core_stall = (state_q == S_STALL) || (state_q == S_READ) || (state_q == S_WRITE);
endmodule

// File: tb/tb_csr_debug_bridge.sv
// Directed bench for csr_debug_bridge with a simple word-write register file.
module tb_csr_debug_bridge;
  import Bundle::*;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [11:0]           req_addr;
  logic [31:0]           req_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  ControlRegisterCommand core_csr_cmd;
  logic [11:0]           core_csr;
  logic [31:0]           core_csr_wdata;
  logic                  core_stall;
  ControlRegisterCommand csr_cmd;
  logic [11:0]           csr;
  logic [31:0]           csr_wdata;
  logic [31:0]           csr_rdata;

  csr_debug_bridge #(.width(32), .timeout(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .core_csr_cmd(core_csr_cmd), .core_csr(core_csr), .core_csr_wdata(core_csr_wdata),
    .core_stall(core_stall),
    .csr_cmd(csr_cmd), .csr(csr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] rf [0:4095];
  int          bw_cnt = 0;
  logic [31:0] bw_data = '0;

  assign csr_rdata = rf[csr];

  always @(posedge clk) begin
    if (csr_cmd == CSR_W) rf[csr] <= csr_wdata;
    if (csr_cmd == CSR_W && core_csr_cmd == CSR_N) begin
      bw_cnt  = bw_cnt + 1;
      bw_data = csr_wdata;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    if (obs !== expd) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expd);
    end
  endtask

  // lat counts cycles from the one after acceptance (1) to the first resp_valid cycle.
  task automatic do_req(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data,
                        output int lat, output logic [31:0] rd, output logic er, output logic st);
    req_op = op; req_addr = addr; req_data = data; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata; er = resp_err; st = core_stall;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, n, bw0;
    logic [31:0] rd;
    logic        er, st;

    reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0;
    resp_ready = 1'b0; core_csr_cmd = CSR_N; core_csr = 12'h123; core_csr_wdata = '0;
    for (int i = 0; i < 4096; i++) rf[i] = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_err",   32'(resp_err), 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_core_stall", 32'(core_stall), 0);
    check("rst_req_ready",  32'(req_ready), 1);
    check("rst_csr_pass",   32'(csr), 32'h123);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // WRITE then READ back
    bw0 = bw_cnt;
    do_req(2'd1, 12'hF, 32'hDEADBEEF, lat, rd, er, st);
    check("wr_lat",     lat, 4);
    check("wr_old",     rd, 32'h0);
    check("wr_err",     32'(er), 0);
    check("wr_once",    bw_cnt - bw0, 1);
    check("wr_wdata",   bw_data, 32'hDEADBEEF);
    check("wr_rf",      rf[15], 32'hDEADBEEF);
    bw0 = bw_cnt;
    do_req(2'd0, 12'hF, 32'h0, lat, rd, er, st);
    check("rd_lat",     lat, 3);
    check("rd_data",    rd, 32'hDEADBEEF);
    check("rd_err",     32'(er), 0);
    check("rd_no_wr",   bw_cnt - bw0, 0);

    // SET / CLEAR
    do_req(2'd1, 12'hF, 32'h00000F00, lat, rd, er, st);
    do_req(2'd2, 12'hF, 32'h000000F0, lat, rd, er, st);
    check("set_lat",    lat, 4);
    check("set_old",    rd, 32'h00000F00);
    check("set_rf",     rf[15], 32'h00000FF0);
    do_req(2'd3, 12'hF, 32'h00000F00, lat, rd, er, st);
    check("clr_old",    rd, 32'h00000FF0);
    check("clr_rf",     rf[15], 32'h000000F0);

    // Response backpressure with an ignored request pulse
    req_op = 2'd0; req_addr = 12'hF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_lat", n, 2);
    bw0 = bw_cnt;
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", 32'(resp_valid), 1);
      check("hold_rdata", resp_rdata, 32'h000000F0);
      check("hold_ready", 32'(req_ready), 0);
      req_valid = (k == 2); req_op = 2'd1; req_addr = 12'hF; req_data = 32'hBAD;
      @(posedge clk); #1;
    end
    req_valid = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    check("hs_idle_ready", 32'(req_ready), 1);
    check("hs_resp_clr",   32'(resp_valid), 0);
    @(posedge clk); #1;
    check("hs_not_taken",  32'(req_ready), 1);
    check("hs_no_stall",   32'(core_stall), 0);
    check("hs_no_wr",      bw_cnt - bw0, 0);
    check("hs_rf",         rf[15], 32'h000000F0);

    // Core holds CSR_W for three cycles after the request
    core_csr_cmd = CSR_W; core_csr = 12'hF; core_csr_wdata = 32'h11;
    fork
      do_req(2'd0, 12'hF, 32'h0, lat, rd, er, st);
      begin
        @(posedge clk); #1;
        check("ct_stall",   32'(core_stall), 1);
        check("ct_cmd",     32'(csr_cmd), 32'(CSR_W));
        check("ct_wdata",   csr_wdata, 32'h11);
        repeat (3) @(posedge clk);
        #1;
        core_csr_cmd = CSR_N;
      end
    join
    check("ct_lat",  lat, 6);
    check("ct_data", rd, 32'h11);
    check("ct_err",  32'(er), 0);

    // Core never releases: timeout
    core_csr_cmd = CSR_S; core_csr = 12'h3; core_csr_wdata = 32'h0;
    bw0 = bw_cnt;
    do_req(2'd1, 12'h3, 32'h55, lat, rd, er, st);
    check("to_lat",    lat, 17);
    check("to_err",    32'(er), 1);
    check("to_rdata",  rd, 32'h0);
    check("to_stall",  32'(st), 0);
    check("to_no_wr",  bw_cnt - bw0, 0);
    check("to_rf",     rf[3], 32'h0);
    check("to_errclr", 32'(resp_err), 0);
    core_csr_cmd = CSR_N;

    // Reset while in WRITE
    req_op = 2'd1; req_addr = 12'h5; req_data = 32'hA5; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rw_stall", 32'(core_stall), 1);
    check("rw_cmd",   32'(csr_cmd), 32'(CSR_W));
    check("rw_addr",  32'(csr), 32'h5);
    check("rw_wdata", csr_wdata, 32'hA5);
    reset_n = 1'b0; core_csr_cmd = CSR_I; core_csr = 12'h7;
    #1;
    check("rw_rst_cmd",  32'(csr_cmd), 32'(CSR_I));
    check("rw_rst_addr", 32'(csr), 32'h7);
    @(posedge clk); #1;
    check("rw_valid", 32'(resp_valid), 0);
    check("rw_nostall", 32'(core_stall), 0);
    check("rw_idle",  32'(req_ready), 1);
    check("rw_pass",  32'(csr_cmd), 32'(CSR_I));
    reset_n = 1'b1; core_csr_cmd = CSR_N;
    @(posedge clk); #1;
    check("rw_after", 32'(req_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
